// File: rtl/instr_stream_decompressor_pkg.sv
// Shared types and token-field helpers for the instruction-stream decompressor.
package decomp_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, RAW, EXPAND, DONE} state_e;

  localparam logic [31:0] DEFAULT_NOP = 32'h00000013;
  localparam int unsigned STAT_W      = 32;

  // A token has every bit above the idx/len fields clear (w is zero-extended).
  function automatic logic is_token(input logic [63:0] w, input int unsigned idx_w,
                                    input int unsigned len_w);
    return (w >> (idx_w + len_w)) == 64'd0;
  endfunction

  function automatic logic [63:0] tok_idx(input logic [63:0] w, input int unsigned idx_w);
    return w & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] tok_len(input logic [63:0] w, input int unsigned idx_w,
                                          input int unsigned len_w);
    return (w >> idx_w) & ((64'd1 << len_w) - 64'd1);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] x);
    return (x == '1) ? x : x + STAT_W'(1);
  endfunction

endpackage

// File: rtl/instr_stream_decompressor_dict.sv
// Runtime-loadable expansion dictionary: one synchronous write port, one combinational read port.
module decomp_dict #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned IDX_W   = 4
) (
  input  logic               clk,
  input  logic               we,
  input  logic [IDX_W-1:0]   waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [IDX_W-1:0]   raddr,
  output logic [INSTR_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_stream_decompressor.sv
// Fetch-path decompressor: raw words pass through, tokens expand into dictionary runs.
// Optional per-run statistics counters are enabled by defining DECOMP_STATS_EN.
module instr_stream_decompressor
  import decomp_pkg::*;
#(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          ADDR_W    = 12,
  parameter int unsigned          IDX_W     = 4,
  parameter int unsigned          LEN_W     = 3,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(DEFAULT_NOP)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [ADDR_W-1:0]  word_cnt,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               dict_we,
  input  logic [IDX_W-1:0]   dict_waddr,
  input  logic [INSTR_W-1:0] dict_wdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef DECOMP_STATS_EN
  ,
  output logic [STAT_W-1:0]  stat_raw,
  output logic [STAT_W-1:0]  stat_tok,
  output logic [STAT_W-1:0]  stat_out
`endif
);

  localparam int unsigned SUM_W = IDX_W + 1;

  state_e             state, state_n;
  logic [ADDR_W-1:0]  ptr, ptr_n, rem, rem_n, mem_addr_n;
  logic [IDX_W-1:0]   run_idx, run_idx_n;
  logic [LEN_W-1:0]   run_len, run_len_n, run_k, run_k_n;
  logic [INSTR_W-1:0] instr_n;
  logic               valid_n, err_n, mem_rd_n, busy_n, done_n;
  logic [SUM_W-1:0]   sum;
  logic [INSTR_W-1:0] rd_data, lookup;
  logic               oor, accept, word_is_tok;
`ifdef DECOMP_STATS_EN
  logic [STAT_W-1:0]  stat_raw_n, stat_tok_n, stat_out_n;
`endif

  // Dictionary slot for the next emitted entry: first slot in WAIT, idx+k+1 while expanding.
  always_comb begin
    if (state == WAIT) sum = {1'b0, IDX_W'(tok_idx(64'(mem_rdata), IDX_W))};
    else               sum = {1'b0, run_idx} + SUM_W'(run_k) + SUM_W'(1);
  end

  assign oor         = sum[IDX_W];
  assign lookup      = oor ? NOP_INSTR : rd_data;
  assign accept      = instr_valid && instr_ready;
  assign word_is_tok = is_token(64'(mem_rdata), IDX_W, LEN_W);

  decomp_dict #(.INSTR_W(INSTR_W), .IDX_W(IDX_W)) u_dict (
    .clk   (clk),
    .we    (dict_we),
    .waddr (dict_waddr),
    .wdata (dict_wdata),
    .raddr (sum[IDX_W-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    rem_n     = rem;
    run_idx_n = run_idx;
    run_len_n = run_len;
    run_k_n   = run_k;
    instr_n   = instr;
    valid_n   = instr_valid;
    err_n     = err;
`ifdef DECOMP_STATS_EN
    stat_raw_n = stat_raw;
    stat_tok_n = stat_tok;
    stat_out_n = stat_out;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          ptr_n   = base_addr;
          rem_n   = word_cnt;
          err_n   = 1'b0;
          state_n = (word_cnt == '0) ? DONE : REQ;
`ifdef DECOMP_STATS_EN
          stat_raw_n = '0;
          stat_tok_n = '0;
          stat_out_n = '0;
`endif
        end
      end
      REQ: begin
        ptr_n   = ptr + ADDR_W'(1);
        rem_n   = rem - ADDR_W'(1);
        state_n = WAIT;
      end
      WAIT: begin
        valid_n = 1'b1;
        if (word_is_tok) begin
          run_idx_n = IDX_W'(tok_idx(64'(mem_rdata), IDX_W));
          run_len_n = LEN_W'(tok_len(64'(mem_rdata), IDX_W, LEN_W));
          run_k_n   = '0;
          instr_n   = lookup;
          err_n     = err | oor;
          state_n   = EXPAND;
        end else begin
          instr_n = mem_rdata;
          state_n = RAW;
        end
      end
      RAW: begin
        if (accept) begin
          valid_n = 1'b0;
          state_n = (rem != '0) ? REQ : DONE;
`ifdef DECOMP_STATS_EN
          stat_raw_n = sat_inc(stat_raw);
          stat_out_n = sat_inc(stat_out);
`endif
        end
      end
      EXPAND: begin
        if (accept) begin
`ifdef DECOMP_STATS_EN
          stat_out_n = sat_inc(stat_out);
`endif
          if (run_k == run_len) begin
            valid_n = 1'b0;
            state_n = (rem != '0) ? REQ : DONE;
`ifdef DECOMP_STATS_EN
            stat_tok_n = sat_inc(stat_tok);
`endif
          end else begin
            run_k_n = run_k + LEN_W'(1);
            instr_n = lookup;
            err_n   = err | oor;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    mem_rd_n   = (state_n == REQ);
    mem_addr_n = (state_n == REQ) ? ptr_n : mem_addr;
    busy_n     = (state_n != IDLE);
    done_n     = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      rem         <= '0;
      run_idx     <= '0;
      run_len     <= '0;
      run_k       <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef DECOMP_STATS_EN
      stat_raw    <= '0;
      stat_tok    <= '0;
      stat_out    <= '0;
`endif
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      rem         <= rem_n;
      run_idx     <= run_idx_n;
      run_len     <= run_len_n;
      run_k       <= run_k_n;
      instr       <= instr_n;
      instr_valid <= valid_n;
      err         <= err_n;
      mem_rd      <= mem_rd_n;
      mem_addr    <= mem_addr_n;
      busy        <= busy_n;
      done        <= done_n;
`ifdef DECOMP_STATS_EN
      stat_raw    <= stat_raw_n;
      stat_tok    <= stat_tok_n;
      stat_out    <= stat_out_n;
`endif
    end
  end

endmodule

// File: tb/tb_instr_stream_decompressor.sv
// Directed scoreboard bench for instr_stream_decompressor (default parameters).
module tb_instr_stream_decompressor;

  logic        clk = 1'b0;
  logic        rst, start, dict_we, instr_ready;
  logic [11:0] base_addr, word_cnt, mem_addr;
  logic        mem_rd, instr_valid, busy, done, err;
  logic [31:0] mem_rdata, dict_wdata, instr;
  logic [3:0]  dict_waddr;
`ifdef DECOMP_STATS_EN
  logic [31:0] stat_raw, stat_tok, stat_out;
`endif

  localparam logic [31:0] NOP = 32'h00000013;

  logic [31:0] img [0:4095];
  logic [31:0] dmodel [0:15];
  logic [31:0] q [$];
  int total = 0, bad = 0, done_cnt = 0, acc_cnt = 0, rd_cnt = 0;
  logic        hold_pend = 1'b0;
  logic [31:0] hold_val = '0;

  instr_stream_decompressor dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .dict_we(dict_we), .dict_waddr(dict_waddr), .dict_wdata(dict_wdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .busy(busy), .done(done), .err(err)
`ifdef DECOMP_STATS_EN
    , .stat_raw(stat_raw), .stat_tok(stat_tok), .stat_out(stat_out)
`endif
  );

  always #5 clk = ~clk;

  // Compressed memory: data appears the cycle after the read strobe.
  always @(posedge clk) if (mem_rd) mem_rdata <= img[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops on every handshake, holds checked under backpressure.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (done) done_cnt++;
    if (mem_rd) rd_cnt++;
    if (!rst && hold_pend) begin
      check("hold_valid", 32'(instr_valid), 32'd1);
      check("hold_instr", instr, hold_val);
    end
    hold_pend = !rst && instr_valid && !instr_ready;
    hold_val  = instr;
    if (!rst && instr_valid && instr_ready) begin
      acc_cnt++;
      exp = (q.size() > 0) ? q.pop_front() : 32'hDEADBEEF;
      check("instr_order", instr, exp);
    end
  end

  task automatic dict_write(input int i, input logic [31:0] d);
    @(negedge clk);
    dict_we = 1'b1; dict_waddr = 4'(i); dict_wdata = d;
    dmodel[i] = d;
    @(posedge clk);
    #1 dict_we = 1'b0;
  endtask

  task automatic push_expected(input int base, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      logic [31:0] w;
      w = img[12'(base + i)];
      if (w[31:7] == 25'd0) begin
        for (int k = 0; k <= int'(w[6:4]); k++) begin
          int s;
          s = int'(w[3:0]) + k;
          q.push_back((s >= 16) ? NOP : dmodel[s]);
        end
      end else begin
        q.push_back(w);
      end
    end
  endtask

  task automatic pulse_start(input int base, input int cnt);
    @(negedge clk);
    base_addr = 12'(base); word_cnt = 12'(cnt); start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_all_out"}, 32'(q.size()), 32'd0);
  endtask

  task automatic wait_acc(input int target);
    int n;
    n = 0;
    while (acc_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, a0;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0;
    dict_we = 1'b0; dict_waddr = '0; dict_wdata = '0; instr_ready = 1'b1;
    for (int i = 0; i < 4096; i++) img[i] = 32'hFFFF0000 | 32'(i);
    img[0]    = 32'h00500093; img[1]  = 32'h00A00113;
    img[16]   = 32'h00000023; img[17] = 32'h00B00193;
    img[32]   = 32'h0000007E;
    img[4095] = 32'h11111111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_instr", instr, 32'd0);

    for (int i = 0; i < 16; i++)
      dict_write(i, (i >= 3 && i <= 5) ? 32'hAAAA00A1 + 32'(i - 3) : 32'hD0D00000 + 32'(i));

    // Raw pass-through with first-fetch latency
    push_expected(0, 2);
    d0 = done_cnt; r0 = rd_cnt;
    pulse_start(0, 2);
    @(negedge clk);
    check("t1_mem_rd", 32'(mem_rd), 32'd1);
    check("t1_mem_addr", 32'(mem_addr), 32'd0);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_valid_wait", 32'(instr_valid), 32'd0);
    @(negedge clk);
    check("t1_valid_lat3", 32'(instr_valid), 32'd1);
    wait_done("t1", d0);
    check("t1_reads", 32'(rd_cnt - r0), 32'd2);
    check("t1_err", 32'(err), 32'd0);

    // Token run followed by raw word
    push_expected(16, 2);
    d0 = done_cnt;
    pulse_start(16, 2);
    wait_done("t2", d0);
    check("t2_err", 32'(err), 32'd0);

    // Backpressure mid-run
    push_expected(16, 2);
    d0 = done_cnt; a0 = acc_cnt;
    pulse_start(16, 2);
    wait_acc(a0 + 1);
    @(posedge clk); #1 instr_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1 instr_ready = 1'b1;
    wait_done("t3", d0);
    check("t3_accepts", 32'(acc_cnt - a0), 32'd4);

    // Out-of-range run
    push_expected(32, 1);
    d0 = done_cnt;
    pulse_start(32, 1);
    wait_done("t4", d0);
    check("t4_err", 32'(err), 32'd1);

    // Zero-length job: done next cycle, no fetch, err cleared by start
    d0 = done_cnt; r0 = rd_cnt;
    pulse_start(5, 0);
    @(negedge clk);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err_clr", 32'(err), 32'd0);
    @(negedge clk);
    check("t5_done_pulse", 32'(done), 32'd0);
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_reads", 32'(rd_cnt - r0), 32'd0);

    // Address wrap, with a start while busy that must be ignored
    push_expected(4095, 2);
    d0 = done_cnt;
    pulse_start(4095, 2);
    @(negedge clk);
    pulse_start(16, 3);
    wait_done("t5w", d0);

    // Reset mid-expansion, then replay
    push_expected(32, 1);
    a0 = acc_cnt;
    pulse_start(32, 1);
    wait_acc(a0 + 3);
    @(posedge clk); #1 begin rst = 1'b1; instr_ready = 1'b0; end
    @(posedge clk); #1 begin rst = 1'b0; instr_ready = 1'b1; end
    @(negedge clk);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_valid", 32'(instr_valid), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    q.delete();
    d0 = done_cnt;
    push_expected(0, 2);
    pulse_start(0, 2);
    wait_done("t6", d0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
